// File: rtl/framing_decoder_param_if.sv
// framing_decoder_param_if: bit-in / word-out bus of the frame decoder
// master drives the demodulated bit stream and observes decoded words and frame status;
// slave is the decoder side.
interface framing_decoder_param_if #(
  parameter int DATA_W = 8
);
  logic              data_in;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_last;
  logic              sync_det;
  logic              frame_done;
  logic              frame_ok;
  logic              frame_err;
  logic              busy;
  modport master (
    output data_in, data_in_valid,
    input  data_out, data_out_valid, data_out_last, sync_det, frame_done, frame_ok, frame_err, busy
  );
  modport slave (
    input  data_in, data_in_valid,
    output data_out, data_out_valid, data_out_last, sync_det, frame_done, frame_ok, frame_err, busy
  );
endinterface

// File: rtl/framing_decoder_param.sv
// framing_decoder_param: sync hunt, LFSR dewhitening, word packing and length-framed payload output
// Ports: clk, rst (sync, active-high), bus (framing_decoder_param_if.slave):
//   data_in/data_in_valid in; data_out/_valid/_last, sync_det, frame_done, frame_ok, frame_err, busy out.
// Macro FRAMING_CRC_EN adds a trailing CRC word check after the payload.
module framing_decoder_param #(
  parameter int                 DATA_W    = 8,
  parameter int                 SYNC_LEN  = 32,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 32'hD391D391,
  parameter int                 MAX_ERR   = 0,
  parameter int                 LFSR_W    = 9,
  parameter logic [LFSR_W-1:0]  LFSR_POLY = 9'h021,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 9'h1FF,
  parameter int                 MAX_LEN   = 255,
  parameter logic [DATA_W-1:0]  CRC_POLY  = 8'h07
) (
  input logic clk,
  input logic rst,
  framing_decoder_param_if.slave bus
);
  localparam int CW = $clog2(SYNC_LEN + 1);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CRC} state_t;
`ifdef FRAMING_CRC_EN
  localparam state_t POST_PAY = CRC;
`else
  localparam state_t POST_PAY = HUNT;
`endif
  state_t              state_q, state_d;
  logic [SYNC_LEN-2:0] sync_q, sync_d;
  logic [CW-1:0]       scnt_q, scnt_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-2:0]   word_q, word_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dv_q, dv_d, last_q, last_d, sdet_q, sdet_d;
  logic                done_q, done_d, ok_q, ok_d, err_q, err_d;
  logic [SYNC_LEN-1:0] sync_nxt;
  logic [DATA_W-1:0]   word_nxt;
  logic [LFSR_W-1:0]   lfsr_adv;
  logic                match, wdone, bad_len, last_w;
  function automatic int popcnt(input logic [SYNC_LEN-1:0] v);
    popcnt = 0;
    for (int i = 0; i < SYNC_LEN; i++) popcnt += int'(v[i]);
  endfunction
  // sync_q keeps only the older SYNC_LEN-1 bits; the newest bit comes straight from the input
  assign sync_nxt = {sync_q, bus.data_in};
  assign match    = scnt_q >= CW'(SYNC_LEN - 1) && popcnt(sync_nxt ^ SYNC_WORD) <= MAX_ERR;
  assign word_nxt = {word_q, bus.data_in ^ lfsr_q[0]};
  assign lfsr_adv = {^(lfsr_q & LFSR_POLY), lfsr_q[LFSR_W-1:1]};
  assign wdone    = bus.data_in_valid && bit_q == BW'(DATA_W - 1);
  assign bad_len  = word_nxt == '0 || 32'(word_nxt) > MAX_LEN;
  assign last_w   = rem_q == DATA_W'(1);
`ifdef FRAMING_CRC_EN
  logic [DATA_W-1:0] crc_q, crc_d;
  function automatic logic [DATA_W-1:0] crc_upd(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] w);
    crc_upd = c;
    for (int i = DATA_W - 1; i >= 0; i--)
      crc_upd = {crc_upd[DATA_W-2:0], 1'b0} ^ ((crc_upd[DATA_W-1] ^ w[i]) ? CRC_POLY : '0);
  endfunction
  always_ff @(posedge clk) crc_q <= rst ? '1 : crc_d;
`else
  logic unused_crc;
  assign unused_crc = ^CRC_POLY;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sync_q  <= '0;
      scnt_q  <= '0;
      lfsr_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      sdet_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      scnt_q  <= scnt_d;
      lfsr_q  <= lfsr_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      sdet_q  <= sdet_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (bus.data_in_valid)
      unique case (state_q)
        HUNT:    if (match) state_d = LEN;
        LEN:     if (wdone) state_d = bad_len ? HUNT : PAYLOAD;
        PAYLOAD: if (wdone && last_w) state_d = POST_PAY;
        default: if (wdone) state_d = HUNT;
      endcase
  end
  always_comb begin
    sync_d = sync_q;
    scnt_d = scnt_q;
    lfsr_d = lfsr_q;
    bit_d  = bit_q;
    word_d = word_q;
    rem_d  = rem_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    last_d = 1'b0;
    sdet_d = 1'b0;
    done_d = 1'b0;
    ok_d   = 1'b0;
    err_d  = 1'b0;
`ifdef FRAMING_CRC_EN
    crc_d  = crc_q;
`endif
    if (bus.data_in_valid && state_q == HUNT) begin
      // leaving HUNT clears the hunt history so the next frame needs a full fresh sync window
      sync_d = match ? '0 : sync_nxt[SYNC_LEN-2:0];
      scnt_d = match ? '0 : (scnt_q == CW'(SYNC_LEN) ? scnt_q : scnt_q + 1'b1);
      lfsr_d = match ? LFSR_SEED : lfsr_q;
      bit_d  = '0;
      sdet_d = match;
`ifdef FRAMING_CRC_EN
      crc_d  = '1;
`endif
    end else if (bus.data_in_valid) begin
      lfsr_d = lfsr_adv;
      word_d = word_nxt[DATA_W-2:0];
      bit_d  = wdone ? '0 : bit_q + 1'b1;
      if (wdone && state_q == LEN) begin
        rem_d  = word_nxt;
        done_d = bad_len;
        err_d  = bad_len;
      end
      if (wdone && state_q == PAYLOAD) begin
        dout_d = word_nxt;
        dv_d   = 1'b1;
        rem_d  = rem_q - 1'b1;
        last_d = last_w;
`ifdef FRAMING_CRC_EN
        crc_d  = crc_upd(crc_q, word_nxt);
`else
        done_d = last_w;
        ok_d   = last_w;
`endif
      end
`ifdef FRAMING_CRC_EN
      if (wdone && state_q == CRC) begin
        done_d = 1'b1;
        ok_d   = word_nxt == crc_q;
        err_d  = word_nxt != crc_q;
      end
`endif
    end
  end
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dv_q;
  assign bus.data_out_last  = last_q;
  assign bus.sync_det       = sdet_q;
  assign bus.frame_done     = done_q;
  assign bus.frame_ok       = ok_q;
  assign bus.frame_err      = err_q;
  assign bus.busy           = state_q != HUNT;
endmodule
